// File: rtl/ds_linebuf_sequencer.sv
// Row/column sequencer for the 2x2 downsample line buffer.
// Writes even rows, reads odd rows, flags complete 2x2 windows.
module ds_linebuf_sequencer #(
  parameter int AWIDTH = 11,
  parameter int HWIDTH = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [AWIDTH-1:0] width,
  input  logic [HWIDTH-1:0] height,
  input  logic              valid_in,
  input  logic              sof_in,
  output logic              wr_en,
  output logic              rd_en,
  output logic [AWIDTH-1:0] col,
  output logic [HWIDTH-1:0] row,
  output logic              ds_valid,
  output logic              ds_last,
  output logic              eof_out,
  output logic              busy,
  output logic              sync_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVEN = 2'd1;
  localparam logic [1:0] ODD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        r_state;
  logic [AWIDTH-1:0] r_col;
  logic [HWIDTH-1:0] r_row;
  logic [AWIDTH-1:0] r_wr_w;
  logic [HWIDTH-1:0] r_ht_w;
  logic              r_ds_valid;
  logic              r_ds_last;
  logic              r_eof;
  logic              r_busy;
  logic              r_sync_err;

  logic w_accept;
  logic w_last_col;
  logic w_last_row;
  logic w_odd;

  assign w_accept   = clken & valid_in;
  assign w_last_col = (r_col == r_wr_w - AWIDTH'(1));
  assign w_last_row = (r_row == r_ht_w - HWIDTH'(1));
  assign w_odd      = (r_state == ODD);

  // wr_en is left ungated; the address generator applies clken itself
  assign wr_en = valid_in &
                 ((r_state == EVEN) | ((r_state == IDLE) & sof_in));
  assign rd_en = w_accept & w_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_wr_w     <= '0;
      r_ht_w     <= '0;
      r_ds_valid <= 1'b0;
      r_ds_last  <= 1'b0;
      r_eof      <= 1'b0;
      r_busy     <= 1'b0;
      r_sync_err <= 1'b0;
    end else if (clken) begin
      r_ds_valid <= 1'b0;
      r_ds_last  <= 1'b0;
      r_eof      <= 1'b0;
      if (w_accept && sof_in && (r_state != IDLE))
        r_sync_err <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_accept && sof_in) begin
            r_wr_w  <= width;
            r_ht_w  <= height;
            r_col   <= AWIDTH'(1);
            r_row   <= '0;
            r_busy  <= 1'b1;
            r_state <= EVEN;
          end
        end
        EVEN, ODD: begin
          if (w_accept) begin
            // window completes on the odd column, one cycle after the read
            r_ds_valid <= w_odd & r_col[0];
            r_ds_last  <= w_odd & r_col[0] & w_last_col & w_last_row;
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) begin
                r_row   <= '0;
                r_state <= DONE;
              end else begin
                r_row   <= r_row + HWIDTH'(1);
                r_state <= w_odd ? EVEN : ODD;
              end
            end else begin
              r_col <= r_col + AWIDTH'(1);
            end
          end
        end
        DONE: begin
          r_eof   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign col      = r_col;
  assign row      = r_row;
  assign ds_valid = r_ds_valid;
  assign ds_last  = r_ds_last;
  assign eof_out  = r_eof;
  assign busy     = r_busy;
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_ds_linebuf_sequencer.sv
// Directed bench for ds_linebuf_sequencer.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ds_linebuf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken;
  logic [10:0] width;
  logic [10:0] height;
  logic        valid_in;
  logic        sof_in;
  logic        wr_en;
  logic        rd_en;
  logic [10:0] col;
  logic [10:0] row;
  logic        ds_valid;
  logic        ds_last;
  logic        eof_out;
  logic        busy;
  logic        sync_err;

  int nerr = 0;
  int nchk = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int ds_cnt = 0;
  int w0, r0, d0;
  logic ck_q = 1'b0;

  ds_linebuf_sequencer #(.AWIDTH(11), .HWIDTH(11)) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .width(width), .height(height),
    .valid_in(valid_in), .sof_in(sof_in),
    .wr_en(wr_en), .rd_en(rd_en),
    .col(col), .row(row),
    .ds_valid(ds_valid), .ds_last(ds_last),
    .eof_out(eof_out), .busy(busy),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // strobe counters; ds_valid counted only when it was freshly loaded
  always @(posedge clk) begin
    if (!rst) begin
      if (wr_en && clken) wr_cnt++;
      if (rd_en) rd_cnt++;
      if (ds_valid && ck_q) ds_cnt++;
    end
    ck_q <= clken;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic c);
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    clken    = c;
    #1;
  endtask

  task automatic snap();
    w0 = wr_cnt;
    r0 = rd_cnt;
    d0 = ds_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clken = 1'b1;
    valid_in = 1'b0;
    sof_in = 1'b0;
    width = 11'd4;
    height = 11'd2;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dsv", ds_valid, 0);
    chk("rst_eof", eof_out, 0);
    chk("rst_serr", sync_err, 0);
    rst = 1'b0;
    cyc(0, 0, 1);

    // basic frame 4x2
    cyc(1, 1, 1);
    chk("b_wr0", wr_en, 1);
    chk("b_rd0", rd_en, 0);
    chk("b_busy0", busy, 0);
    for (int i = 1; i < 4; i++) begin
      cyc(1, 0, 1);
      chk("b_ecol", col, i);
      chk("b_erow", row, 0);
      chk("b_ewr", wr_en, 1);
      chk("b_erd", rd_en, 0);
      chk("b_ebusy", busy, 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1);
      chk("b_ocol", col, i);
      chk("b_orow", row, 1);
      chk("b_ord", rd_en, 1);
      chk("b_owr", wr_en, 0);
      chk("b_odsv", ds_valid, (i == 2) ? 1 : 0);
      chk("b_odsl", ds_last, 0);
    end
    cyc(1, 0, 1);
    chk("b_done_dsv", ds_valid, 1);
    chk("b_done_dsl", ds_last, 1);
    chk("b_done_rd", rd_en, 0);
    chk("b_done_wr", wr_en, 0);
    chk("b_done_busy", busy, 1);
    cyc(0, 0, 1);
    chk("b_eof", eof_out, 1);
    chk("b_busy_end", busy, 0);
    chk("b_dsv_end", ds_valid, 0);
    chk("b_col_end", col, 0);
    chk("b_row_end", row, 0);
    cyc(0, 0, 1);
    chk("b_eof_pulse", eof_out, 0);

    // bubbles 4x4
    height = 11'd4;
    snap();
    for (int p = 0; p < 16; p++) begin
      cyc(1, (p == 0), 1);
      cyc(0, 0, 1);
      chk("bub_wr_gap", wr_en, 0);
      chk("bub_rd_gap", rd_en, 0);
      if (p < 15) begin
        chk("bub_col", col, (p + 1) % 4);
        chk("bub_row", row, (p + 1) / 4);
      end
    end
    cyc(0, 0, 1);
    chk("bub_eof", eof_out, 1);
    cyc(0, 0, 1);
    chk("bub_wrn", wr_cnt - w0, 8);
    chk("bub_rdn", rd_cnt - r0, 8);
    chk("bub_dsn", ds_cnt - d0, 4);

    // clken stall mid odd row, 4x2
    height = 11'd2;
    snap();
    cyc(1, 1, 1);
    repeat (3) cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      chk("ck_rd", rd_en, 0);
      chk("ck_wr", wr_en, 0);
      chk("ck_col", col, 2);
      chk("ck_row", row, 1);
      chk("ck_dsv", ds_valid, 1);
    end
    cyc(1, 0, 1);
    chk("ck_rd_res", rd_en, 1);
    chk("ck_col_res", col, 2);
    cyc(1, 0, 1);
    chk("ck_col3", col, 3);
    chk("ck_dsv0", ds_valid, 0);
    cyc(0, 0, 1);
    chk("ck_dsl", ds_last, 1);
    cyc(0, 0, 1);
    chk("ck_eof", eof_out, 1);
    cyc(0, 0, 1);
    chk("ck_wrn", wr_cnt - w0, 4);
    chk("ck_rdn", rd_cnt - r0, 4);
    chk("ck_dsn", ds_cnt - d0, 2);

    // odd height 2x3
    width = 11'd2;
    height = 11'd3;
    snap();
    cyc(1, 1, 1);
    repeat (3) cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("oh_row2", row, 2);
    chk("oh_wr2", wr_en, 1);
    chk("oh_rd2", rd_en, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    chk("oh_busy", busy, 1);
    cyc(0, 0, 1);
    chk("oh_eof", eof_out, 1);
    cyc(0, 0, 1);
    chk("oh_wrn", wr_cnt - w0, 4);
    chk("oh_rdn", rd_cnt - r0, 2);
    chk("oh_dsn", ds_cnt - d0, 1);

    // sof mid-frame, 4x2
    width = 11'd4;
    height = 11'd2;
    cyc(1, 1, 1);
    repeat (5) cyc(1, 0, 1);
    cyc(1, 1, 1);
    chk("se_col", col, 2);
    chk("se_pre", sync_err, 0);
    cyc(1, 0, 1);
    chk("se_set", sync_err, 1);
    chk("se_col3", col, 3);
    cyc(0, 0, 1);
    chk("se_dsl", ds_last, 1);
    cyc(0, 0, 1);
    chk("se_eof", eof_out, 1);
    chk("se_sticky", sync_err, 1);

    // async reset mid row
    cyc(1, 1, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("ar_pre_col", col, 2);
    rst = 1'b1;
    #1;
    chk("ar_col", col, 0);
    chk("ar_row", row, 0);
    chk("ar_busy", busy, 0);
    chk("ar_serr", sync_err, 0);
    chk("ar_wr", wr_en, 0);
    cyc(1, 0, 1);
    rst = 1'b0;
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("ar_ign_col", col, 0);
    chk("ar_ign_busy", busy, 0);
    chk("ar_ign_wr", wr_en, 0);
    cyc(1, 1, 1);
    chk("ar_sof_wr", wr_en, 1);
    cyc(0, 0, 1);
    chk("ar_new_col", col, 1);
    chk("ar_new_row", row, 0);
    chk("ar_new_busy", busy, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ds_linebuf_sequencer.md
Name: ds_linebuf_sequencer

Overview:
- Frame/row sequencer for the 2x2 downsample line buffer.
- Counts pixel column and row over an incoming stream and drives the wr_en/rd_en strobes consumed by the line-buffer address generator: write on even rows, read on odd rows.
- Flags the cycles where a complete 2x2 window (buffered even-row pixel plus live odd-row pixel) is available to the downsample datapath.

Parameters:
- AWIDTH, 11, width of column counter and width input; max line 2^AWIDTH-1 pixels
- HWIDTH, 11, width of row counter and height input

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- clken  in  1  global clock enable; all state advances only when high
- width  in  AWIDTH  pixels per row; sampled at frame start; legal 2..2^AWIDTH-1, even
- height  in  HWIDTH  rows per frame; sampled at frame start; legal >=2
- valid_in  in  1  input pixel valid
- sof_in  in  1  start-of-frame, qualifies first pixel (with valid_in)
- wr_en  out  1  line-buffer write strobe (combinational)
- rd_en  out  1  line-buffer read strobe (combinational, already gated by clken&valid_in)
- col  out  AWIDTH  column of the next expected pixel (registered)
- row  out  HWIDTH  row of the next expected pixel (registered)
- ds_valid  out  1  registered pulse: 2x2 window complete
- ds_last  out  1  registered; with ds_valid, last window of frame
- eof_out  out  1  registered one-cycle end-of-frame pulse
- busy  out  1  high while a frame is in progress
- sync_err  out  1  sticky; sof_in seen mid-frame; cleared only by rst

Behaviour:
- Accept = clken & valid_in. No counter/state change without accept, except DONE->IDLE (needs clken only).
- Reset (rst=1, async): state IDLE; col=0, row=0; ds_valid=0, ds_last=0, eof_out=0, busy=0, sync_err=0; wr_w/ht_w shadow regs=0.
- States:
  - IDLE: accept with sof_in -> latch width/height; pixel is row0 col0 and is written; col<=1; go EVEN; busy<=1. Accept without sof_in is dropped.
  - EVEN: each accept writes, col++.
  - ODD: each accept reads, col++.
  - DONE: eof_out<=1 for one cycle, busy<=0, go IDLE.
- Strobes:
  - wr_en = valid_in & (state==EVEN | (state==IDLE & sof_in)).
  - rd_en = clken & valid_in & state==ODD.
  - Address generator sees one strobe per accepted pixel, so read and write pointers stay aligned and wrap together at width-1.
- Row end: accept at col==wr_w-1 -> col<=0, row++.
  - State toggles EVEN<->ODD.
  - If row==ht_w-1, go DONE and row<=0 instead.
  - Odd height: last (even) row is written, never read; DONE follows it.
- ds_valid: registered 1 cycle after an accept in ODD at odd col. Aligns with 1-cycle SRAM read latency of the pixel at the same column.
  - One pulse per 2 columns of each odd row: (wr_w/2) pulses per odd row.
- ds_last = ds_valid for accept at col==wr_w-1 in the final odd row (row==ht_w-1).
- sof_in with accept while in EVEN/ODD/DONE:
  - set sync_err; pixel processed as an ordinary pixel.
  - No restart: the address generator has no frame reset.
- width/height changes mid-frame ignored; shadow values used until IDLE.
- clken low: strobes suppressed (rd_en by gating; wr_en by address-generator clken), all regs hold, including a pending DONE.
- Back-to-back frames: sof accepted in the cycle after DONE (state IDLE) starts a new frame with zero bubble beyond the DONE cycle.

Test Plan:
- Basic frame: width=4, height=2, continuous valid.
  - Row0: wr_en high 4 cycles, rd_en low.
  - Row1: rd_en high 4 cycles, wr_en low.
  - ds_valid pulses after col1 and col3; second pulse carries ds_last.
  - eof_out one cycle after DONE entry; busy 1->0.
- Bubbles: width=4, height=4, valid_in toggling 1/0.
  - Exactly 8 wr_en-qualified and 8 rd_en pulses.
  - 4 ds_valid pulses; col/row hold during gaps.
- clken low for 3 cycles mid-ODD row with valid_in high: rd_en=0; col/row/state frozen; sequence resumes identically.
- Odd height=3, width=2: rows 0 and 2 written, row1 read; 1 ds_valid; eof after row2.
- sof_in asserted at row1 col2: sync_err=1 sticky; frame completes normally.
- Async rst asserted mid-row: all outputs zero immediately; next sof starts row0 col0; pixels before sof ignored.
